// File: rtl/nexys_starship_spawn_ctrl.sv
// Starship monster controller: INIT/PLAY/OVER FSM that spawns at four positions, scores kills and detects attack timeouts.
// Define NEXYS_STARSHIP_SPAWN_LFSR_EN to start the free-position search at an 8-bit LFSR instead of the round-robin pointer.
module nexys_starship_spawn_ctrl #(
    parameter int SPAWN_INTERVAL = 16,
    parameter int ATTACK_TIMEOUT = 64
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       play,
    input  logic [3:0] kill,
    output logic [3:0] spawn,
    output logic [3:0] occupied,
    output logic [7:0] score,
    output logic       game_over,
    output logic       q_Init,
    output logic       q_Play,
    output logic       q_Over
);

    localparam int CW = $clog2(SPAWN_INTERVAL);
    localparam int TW = $clog2(ATTACK_TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(SPAWN_INTERVAL - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(ATTACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        INIT = 3'b001,
        PLAY = 3'b010,
        OVER = 3'b100
    } state_t;

    state_t        state;
    logic [CW-1:0] spawn_cnt;
    logic [TW-1:0] timer [4];
    logic [1:0]    ptr;
    logic [1:0]    search_start;

    logic [3:0]    kill_acc;
    logic [3:0]    occ_kept;
    logic [3:0]    timeout;
    logic          any_empty;
    logic          found;
    logic [1:0]    cand;
    logic [1:0]    sel_idx;
    logic [3:0]    sel_oh;
    logic [2:0]    kill_pop;
    logic [8:0]    score_sum;
    logic [7:0]    score_next;

`ifdef NEXYS_STARSHIP_SPAWN_LFSR_EN
    logic [7:0] lfsr;

    // Fibonacci taps 8,6,5,4; free-runs in every state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) lfsr <= 8'h01;
        else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    assign search_start = lfsr[1:0];
`else
    assign search_start = ptr;
`endif

    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no path can infer a latch.
        kill_acc = kill & occupied;
        occ_kept = occupied & ~kill_acc;
        timeout  = '0;
        for (int i = 0; i < 4; i++) begin
            timeout[i] = occupied[i] && !kill_acc[i] && (timer[i] == TMR_LAST);
        end

        // Selection looks only at occupancy registered before this edge.
        any_empty = ~&occupied;
        found     = 1'b0;
        cand      = search_start;
        sel_idx   = search_start;
        for (int k = 0; k < 4; k++) begin
            cand = search_start + 2'(k);
            if (!found && !occupied[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
        sel_oh = 4'b0001 << sel_idx;

        kill_pop   = {2'b00, kill_acc[0]} + {2'b00, kill_acc[1]}
                   + {2'b00, kill_acc[2]} + {2'b00, kill_acc[3]};
        score_sum  = {1'b0, score} + {6'b000000, kill_pop};
        score_next = score_sum[8] ? 8'hFF : score_sum[7:0];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= INIT;
            occupied  <= '0;
            spawn     <= '0;
            score     <= '0;
            spawn_cnt <= '0;
            ptr       <= '0;
            // NOTE: the timers are four ordinary flops rather than a RAM, so they take the async reset too.
            for (int i = 0; i < 4; i++) timer[i] <= '0;
        end else begin
            // NOTE: non-blocking throughout, so every branch reads the pre-edge value of all state.
            spawn <= '0;
            case (state)
                INIT: begin
                    occupied <= '0;
                    score    <= '0;
                    if (play) begin
                        state     <= PLAY;
                        spawn_cnt <= '0;
                        ptr       <= '0;
                        for (int i = 0; i < 4; i++) timer[i] <= '0;
                    end
                end
                PLAY: begin
                    score <= score_next;
                    if (|timeout) begin
                        // Counters freeze for the OVER display; no spawn on the losing edge.
                        state    <= OVER;
                        occupied <= occ_kept;
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            timer[i] <= occ_kept[i] ? timer[i] + 1'b1 : '0;
                        end
                        if (spawn_cnt != CNT_LAST) begin
                            spawn_cnt <= spawn_cnt + 1'b1;
                            occupied  <= occ_kept;
                        end else if (any_empty) begin
                            occupied  <= occ_kept | sel_oh;
                            spawn     <= sel_oh;
                            spawn_cnt <= '0;
                            ptr       <= sel_idx + 2'd1;
                        end else begin
                            occupied  <= occ_kept;
                        end
                    end
                end
                OVER: begin
                    if (play) begin
                        state    <= INIT;
                        occupied <= '0;
                        score    <= '0;
                    end
                end
                default: begin
                    state    <= INIT;
                    occupied <= '0;
                    score    <= '0;
                end
            endcase
        end
    end

    assign {q_Over, q_Play, q_Init} = state;
    assign game_over                = state[2];

endmodule
